// File: rtl/slow_peripheral_mailbox_pkg.sv
// -----------------------------------------------------------------------------
// slow_peripheral_mailbox_pkg
//   Shared definitions for the slow peripheral mailbox:
//   - register word addresses
//   - STATUS / CONTROL bit positions
//   - read pipeline latency
//   - FIFO entry layout {eop, data}
// -----------------------------------------------------------------------------
package slow_peripheral_mailbox_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_TXDATA     = 3'd0;
    localparam logic [2:0] ADDR_TXDATA_EOP = 3'd1;
    localparam logic [2:0] ADDR_RXDATA     = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_CONTROL    = 3'd4;

    // STATUS bit positions
    localparam int STATUS_TX_LEVEL_LSB = 0;
    localparam int STATUS_RX_LEVEL_LSB = 8;
    localparam int STATUS_TX_FULL      = 16;
    localparam int STATUS_RX_EMPTY     = 17;
    localparam int STATUS_TX_OVERFLOW  = 18;
    localparam int STATUS_RX_UNDERFLOW = 19;

    // CONTROL bit positions
    localparam int CTRL_RX_IRQ_EN     = 0;
    localparam int CTRL_TX_BLOCK      = 1;
    localparam int CTRL_THRESHOLD_LSB = 8;
    localparam int CTRL_THRESHOLD_MSB = 15;

    // Accept-to-readdatavalid latency in clock cycles
    localparam int READ_LATENCY = 2;

    // One FIFO slot: a 32-bit word tagged with its end-of-packet flag
    typedef struct packed {
        logic        eop;
        logic [31:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    // One stage of the read response pipeline
    typedef struct packed {
        logic        valid;
        logic        eop;
        logic [31:0] data;
    } rd_resp_t;

endpackage

// File: rtl/slow_peripheral_sync_fifo.sv
// -----------------------------------------------------------------------------
// slow_peripheral_sync_fifo
//   Single-clock show-ahead FIFO. The head entry is always presented on
//   head_data; push is ignored when full, pop is ignored when empty. Full and
//   empty come from the registered level, so a pop in the same cycle never
//   makes room for a push into a full FIFO.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write request and entry
//   pop               remove the head entry
//   head_data         current head entry (stale when empty)
//   full, empty       registered-level flags
//   level             number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module slow_peripheral_sync_fifo #(
    parameter  int WIDTH   = 33,
    parameter  int DEPTH   = 16,
    localparam int LEVEL_W = $clog2(DEPTH) + 1,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head_data,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (level == LEVEL_W'(DEPTH));
    assign empty     = (level == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by level and
    // pointers alone, which lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/slow_peripheral_mailbox.sv
// -----------------------------------------------------------------------------
// slow_peripheral_mailbox
//   Avalon-MM pipelined slave holding a TX packet FIFO (CPU writes -> local
//   stream) and an RX packet FIFO (local stream -> CPU reads), with level
//   status, sticky error flags and an RX threshold interrupt. Reads have a
//   fixed latency of READ_LATENCY cycles; only TX pushes ever stall.
//
// Ports:
//   clk, reset                    bridge master clock, sync active-high reset
//   address/read/write            Avalon command (word address)
//   byteenable/writedata          write lanes (lanes used on CONTROL only)
//   waitrequest                   stalls TX pushes into a full FIFO (tx_block)
//   readdata/readdatavalid        read response, zero when not valid
//   endofpacket                   EOP tag for RXDATA responses
//   irq                           registered RX threshold interrupt
//   tx_data/tx_eop/tx_valid/tx_ready  TX stream out (show-ahead)
//   rx_data/rx_eop/rx_valid/rx_ready  RX stream in
// -----------------------------------------------------------------------------
module slow_peripheral_mailbox
    import slow_peripheral_mailbox_pkg::*;
#(
    parameter  int DEPTH   = 16,
    localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        endofpacket,
    output logic        irq,
    output logic [31:0] tx_data,
    output logic        tx_eop,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_eop,
    input  logic        rx_valid,
    output logic        rx_ready
);

    fifo_entry_t        tx_head;
    fifo_entry_t        rx_head;
    fifo_entry_t        tx_push_entry;
    fifo_entry_t        rx_push_entry;
    logic               tx_full, tx_empty, rx_full, rx_empty;
    logic [LEVEL_W-1:0] tx_level, rx_level;

    logic               rx_irq_en;
    logic               tx_block;
    logic [7:0]         rx_threshold;
    logic               tx_overflow;
    logic               rx_underflow;

    logic               is_tx_addr;
    logic               wr_accept, rd_accept;
    logic               tx_push_req, tx_drop, tx_pop;
    logic               rx_pop_req, rx_pop_empty, rx_push;
    logic               status_w1c, control_wr;

    logic [31:0]        status_word;
    logic [31:0]        control_word;
    rd_resp_t           rd_head;
    rd_resp_t           rd_pipe [READ_LATENCY];

    // Only the low two byte lanes carry CONTROL fields
    logic               unused_lanes;
    assign unused_lanes = &{1'b0, byteenable[3:2]};

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    assign is_tx_addr  = (address == ADDR_TXDATA) || (address == ADDR_TXDATA_EOP);
    assign waitrequest = write & is_tx_addr & tx_full & tx_block;
    assign wr_accept   = write & ~waitrequest;
    assign rd_accept   = read & ~waitrequest;

    assign tx_push_req  = wr_accept & is_tx_addr;
    // Registered full: a same-cycle stream pop does not rescue the word
    assign tx_drop      = tx_push_req & tx_full;
    assign tx_pop       = tx_valid & tx_ready;

    assign rx_pop_req   = rd_accept & (address == ADDR_RXDATA);
    assign rx_pop_empty = rx_pop_req & rx_empty;
    assign rx_push      = rx_valid & rx_ready;

    assign status_w1c   = wr_accept & (address == ADDR_STATUS);
    assign control_wr   = wr_accept & (address == ADDR_CONTROL);

    assign tx_push_entry = '{eop: (address == ADDR_TXDATA_EOP), data: writedata};
    assign rx_push_entry = '{eop: rx_eop, data: rx_data};

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    slow_peripheral_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push_req),
        .push_data (tx_push_entry),
        .pop       (tx_pop),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    slow_peripheral_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_push_entry),
        .pop       (rx_pop_req),
        .head_data (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_head.data;
    assign tx_eop   = tx_head.eop;
    assign rx_ready = ~rx_full;

    // ------------------------------------------------------------------
    // Register read values
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        status_word = '0;
        status_word[STATUS_TX_LEVEL_LSB +: 8] = 8'(tx_level);
        status_word[STATUS_RX_LEVEL_LSB +: 8] = 8'(rx_level);
        status_word[STATUS_TX_FULL]           = tx_full;
        status_word[STATUS_RX_EMPTY]          = rx_empty;
        status_word[STATUS_TX_OVERFLOW]       = tx_overflow;
        status_word[STATUS_RX_UNDERFLOW]      = rx_underflow;

        control_word = '0;
        control_word[CTRL_RX_IRQ_EN]                          = rx_irq_en;
        control_word[CTRL_TX_BLOCK]                           = tx_block;
        control_word[CTRL_THRESHOLD_MSB:CTRL_THRESHOLD_LSB]   = rx_threshold;
    end

    // Response captured at accept; RXDATA samples the show-ahead head in the
    // same cycle the pop is issued. Non-accepted cycles carry all zeros.
    always_comb begin
        rd_head = '0;
        if (rd_accept) begin
            rd_head.valid = 1'b1;
            case (address)
                ADDR_RXDATA: begin
                    if (!rx_empty) begin
                        rd_head.data = rx_head.data;
                        rd_head.eop  = rx_head.eop;
                    end
                end
                ADDR_STATUS:  rd_head.data = status_word;
                ADDR_CONTROL: rd_head.data = control_word;
                default:      rd_head.data = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fixed-latency read pipeline; reset flushes in-flight responses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] <= '0;
        end else begin
            rd_pipe[0] <= rd_head;
            for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign readdatavalid = rd_pipe[READ_LATENCY-1].valid;
    assign readdata      = rd_pipe[READ_LATENCY-1].data;
    assign endofpacket   = rd_pipe[READ_LATENCY-1].eop;

    // ------------------------------------------------------------------
    // CONTROL, sticky flags, interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_irq_en    <= 1'b0;
            tx_block     <= 1'b0;
            rx_threshold <= '0;
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (control_wr && byteenable[0]) begin
                rx_irq_en <= writedata[CTRL_RX_IRQ_EN];
                tx_block  <= writedata[CTRL_TX_BLOCK];
            end
            if (control_wr && byteenable[1])
                rx_threshold <= writedata[CTRL_THRESHOLD_MSB:CTRL_THRESHOLD_LSB];

            // A new error event takes priority over a simultaneous clear
            if (tx_drop)
                tx_overflow <= 1'b1;
            else if (status_w1c && writedata[STATUS_TX_OVERFLOW])
                tx_overflow <= 1'b0;

            if (rx_pop_empty)
                rx_underflow <= 1'b1;
            else if (status_w1c && writedata[STATUS_RX_UNDERFLOW])
                rx_underflow <= 1'b0;

            irq <= rx_irq_en && (rx_threshold != 8'd0) && (8'(rx_level) >= rx_threshold);
        end
    end

endmodule

// File: tb/tb_slow_peripheral_mailbox.sv
// -----------------------------------------------------------------------------
// tb_slow_peripheral_mailbox
//   Self-checking bench: register table vectors and hand-written sequences
//   feed a read scoreboard (data, eop, expected arrival cycle) and a TX
//   stream scoreboard; monitors pop and compare on the falling edge.
// -----------------------------------------------------------------------------
module tb_slow_peripheral_mailbox;
    import slow_peripheral_mailbox_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        endofpacket;
    logic        irq;
    logic [31:0] tx_data;
    logic        tx_eop;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_eop;
    logic        rx_valid;
    logic        rx_ready;

    slow_peripheral_mailbox #(.DEPTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .endofpacket   (endofpacket),
        .irq           (irq),
        .tx_data       (tx_data),
        .tx_eop        (tx_eop),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_eop        (rx_eop),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        eop;
        int          cyc;
    } rd_exp_t;

    rd_exp_t     sb[$];
    logic [32:0] tx_exp[$];

    typedef struct {
        bit          is_write;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read response monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (readdatavalid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_readdatavalid actual=1 expected=0 data=0x%08h cyc=%0d", readdata, cyc);
                end else begin
                    rd_exp_t e;
                    e = sb.pop_front();
                    check("rd_data", readdata, e.data);
                    check("rd_eop", 32'(endofpacket), 32'(e.eop));
                    check("rd_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (readdata != 32'd0 || endofpacket) begin
                checks++;
                errors++;
                $display("FAIL idle_readdata actual=0x%08h/eop%0b expected=0/eop0", readdata, endofpacket);
            end
        end
    end

    // TX stream monitor
    always @(negedge clk) begin
        if (mon_en && tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx_word actual=0x%08h expected=none", tx_data);
            end else begin
                logic [32:0] e;
                e = tx_exp.pop_front();
                check("tx_data", tx_data, e[31:0]);
                check("tx_eop", 32'(tx_eop), 32'(e[32]));
            end
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        address = a; writedata = d; byteenable = be; write = 1'b1;
        @(negedge clk);
        while (waitrequest && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (waitrequest) begin
            checks++;
            errors++;
            $display("FAIL write_stall_timeout actual=waitrequest1 expected=accept addr=%0d", a);
        end
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp_d, input logic exp_eop);
        rd_exp_t e;
        address = a; read = 1'b1;
        e.data = exp_d; e.eop = exp_eop; e.cyc = cyc + READ_LATENCY;
        sb.push_back(e);
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic drain_reads();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL read_response_timeout actual_pending=%0d expected=0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Register table: writes are applied, reads go to the scoreboard
        vecs[0]  = '{1'b1, ADDR_CONTROL, 32'hFFFF_FFFF, 4'b0001, 32'h0};
        vecs[1]  = '{1'b0, ADDR_CONTROL, 32'h0,         4'b0000, 32'h0000_0003};
        vecs[2]  = '{1'b1, ADDR_CONTROL, 32'h0000_AB00, 4'b0010, 32'h0};
        vecs[3]  = '{1'b0, ADDR_CONTROL, 32'h0,         4'b0000, 32'h0000_AB03};
        vecs[4]  = '{1'b1, ADDR_CONTROL, 32'h1234_56FC, 4'b1100, 32'h0};
        vecs[5]  = '{1'b0, ADDR_CONTROL, 32'h0,         4'b0000, 32'h0000_AB03};
        vecs[6]  = '{1'b1, ADDR_CONTROL, 32'h0000_0000, 4'b1111, 32'h0};
        vecs[7]  = '{1'b0, ADDR_CONTROL, 32'h0,         4'b0000, 32'h0000_0000};
        vecs[8]  = '{1'b1, 3'd5,         32'hDEAD_BEEF, 4'b1111, 32'h0};
        vecs[9]  = '{1'b0, 3'd5,         32'h0,         4'b0000, 32'h0000_0000};
        vecs[10] = '{1'b0, ADDR_TXDATA,  32'h0,         4'b0000, 32'h0000_0000};
        vecs[11] = '{1'b0, 3'd7,         32'h0,         4'b0000, 32'h0000_0000};

        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; byteenable = '0;
        writedata = '0; tx_ready = 1'b0; rx_data = '0; rx_eop = 1'b0; rx_valid = 1'b0;
        idle(3);
        reset = 1'b0;
        mon_en = 1'b1;

        // Reset state
        check("rst_readdatavalid", 32'(readdatavalid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_waitrequest", 32'(waitrequest), 32'd0);
        bus_read(ADDR_STATUS, 32'h0002_0000, 1'b0);
        drain_reads();

        // Register table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_write) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            else                  bus_read(vecs[i].addr, vecs[i].exp, 1'b0);
        end
        drain_reads();
        check("irq_level0", 32'(irq), 32'd0);

        // Basic TX packet
        bus_write(ADDR_TXDATA, 32'h11, 4'hF);     tx_exp.push_back({1'b0, 32'h11});
        bus_write(ADDR_TXDATA, 32'h22, 4'hF);     tx_exp.push_back({1'b0, 32'h22});
        bus_write(ADDR_TXDATA_EOP, 32'h33, 4'hF); tx_exp.push_back({1'b1, 32'h33});
        bus_read(ADDR_STATUS, 32'h0002_0003, 1'b0);
        drain_reads();
        tx_ready = 1'b1;
        idle(6);
        check("tx_basic_drained", 32'(tx_exp.size()), 32'd0);
        bus_read(ADDR_STATUS, 32'h0002_0000, 1'b0);
        drain_reads();
        tx_ready = 1'b0;

        // Overflow with tx_block=0: 16 stored, 17th dropped
        for (int i = 0; i < 17; i++) begin
            bus_write(ADDR_TXDATA, 32'h100 + i, 4'hF);
            if (i < 16) tx_exp.push_back({1'b0, 32'(32'h100 + i)});
        end
        bus_read(ADDR_STATUS, 32'h0007_0010, 1'b0);
        bus_write(ADDR_STATUS, 32'h0004_0000, 4'hF);
        bus_read(ADDR_STATUS, 32'h0003_0010, 1'b0);
        drain_reads();
        tx_ready = 1'b1;
        idle(20);
        tx_ready = 1'b0;
        check("tx_overflow_drained", 32'(tx_exp.size()), 32'd0);

        // Back-pressure with tx_block=1
        bus_write(ADDR_CONTROL, 32'h0000_0002, 4'b0001);
        for (int i = 0; i < 16; i++) begin
            bus_write(ADDR_TXDATA, 32'h200 + i, 4'hF);
            tx_exp.push_back({1'b0, 32'(32'h200 + i)});
        end
        address = ADDR_TXDATA; writedata = 32'h2FF; byteenable = 4'hF; write = 1'b1;
        tx_exp.push_back({1'b0, 32'h2FF});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("tx_block_stall", 32'(waitrequest), 32'd1);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
        check("tx_block_stall_same_cycle_pop", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        check("tx_block_released", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
        write = 1'b0;
        bus_read(ADDR_STATUS, 32'h0003_0010, 1'b0);
        drain_reads();
        bus_write(ADDR_CONTROL, 32'h0, 4'hF);
        tx_ready = 1'b1;
        idle(20);
        check("tx_block_drained", 32'(tx_exp.size()), 32'd0);

        // RX packet with threshold interrupt
        bus_write(ADDR_CONTROL, 32'h0000_0301, 4'hF);
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 32'hA0 + i;
            rx_eop  = (i == 2);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; rx_eop = 1'b0;
        @(negedge clk);
        check("irq_not_yet", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_rise", 32'(irq), 32'd1);
        bus_read(ADDR_RXDATA, 32'hA0, 1'b0);
        bus_read(ADDR_RXDATA, 32'hA1, 1'b0);
        bus_read(ADDR_RXDATA, 32'hA2, 1'b1);
        drain_reads();
        check("irq_fall", 32'(irq), 32'd0);
        bus_write(ADDR_CONTROL, 32'h0, 4'hF);

        // Underflow and W1C
        bus_read(ADDR_RXDATA, 32'h0, 1'b0);
        drain_reads();
        bus_read(ADDR_STATUS, 32'h000A_0000, 1'b0);
        drain_reads();
        bus_write(ADDR_STATUS, 32'h0008_0000, 4'hF);
        bus_read(ADDR_STATUS, 32'h0002_0000, 1'b0);
        drain_reads();

        // Reset with reads in flight
        tx_ready = 1'b0;
        bus_write(ADDR_CONTROL, 32'h0000_0501, 4'hF);
        bus_write(ADDR_TXDATA, 32'h55, 4'hF);
        rx_data = 32'hBB; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        begin
            rd_exp_t e;
            address = ADDR_STATUS; read = 1'b1;
            e.data = 32'h0000_0101; e.eop = 1'b0; e.cyc = cyc + READ_LATENCY;
            sb.push_back(e);   // first response lands before reset takes effect
            @(posedge clk); #1; // second read accepted here, must be discarded
            @(posedge clk); #1;
            read = 1'b0;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
        idle(4);
        check("reset_inflight_pending", 32'(sb.size()), 32'd0);
        check("reset2_tx_valid", 32'(tx_valid), 32'd0);
        check("reset2_rx_ready", 32'(rx_ready), 32'd1);
        check("reset2_irq", 32'(irq), 32'd0);
        bus_read(ADDR_STATUS, 32'h0002_0000, 1'b0);
        bus_read(ADDR_CONTROL, 32'h0, 1'b0);
        drain_reads();

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
